ram_bus_master: RTL

//  Converts memory_control's single-beat RAM requests (ramaddr/ramstore/Ren/Wen) into

---
 rtl/ram_bus_master_if.sv | 33 +++
 rtl/ram_bus_master.sv | 88 ++++++++
 2 files changed

// File: rtl/ram_bus_master_if.sv
// ram_bus_master_if: memory_control request/response signals plus the Wishbone B4 classic master bus.
// The master modport is the bridge's view; slave is the view of the requester/SRAM side.
interface ram_bus_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   ramaddr;
    logic [DATA_W-1:0]   ramstore;
    logic                Ren;
    logic                Wen;
    logic [DATA_W-1:0]   ramload;
    logic                busy_o;
    logic                err_o;
    logic [ADDR_W-1:0]   ADR_O;
    logic [DATA_W-1:0]   DAT_O;
    logic [DATA_W/8-1:0] SEL_O;
    logic                WE_O;
    logic                CYC_O;
    logic                STB_O;
    logic [DATA_W-1:0]   DAT_I;
    logic                ACK_I;
    logic                ERR_I;

    modport master (
        input  ramaddr, ramstore, Ren, Wen, DAT_I, ACK_I, ERR_I,
        output ramload, busy_o, err_o, ADR_O, DAT_O, SEL_O, WE_O, CYC_O, STB_O
    );

    modport slave (
        output ramaddr, ramstore, Ren, Wen, DAT_I, ACK_I, ERR_I,
        input  ramload, busy_o, err_o, ADR_O, DAT_O, SEL_O, WE_O, CYC_O, STB_O
    );
endinterface

// File: rtl/ram_bus_master.sv
// ram_bus_master: turns single-beat Ren/Wen RAM requests into Wishbone classic cycles,
// with ERR_I and a wait-cycle timeout both completing the request with ERR_DATA.
module ram_bus_master #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hBAD0_BAD0
) (
    input  logic                 CLK,
    input  logic                 RST,
    ram_bus_master_if.master     bus
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_adr;
    logic [DATA_W-1:0]   r_dat;
    logic                r_we;
    logic [DATA_W-1:0]   r_load;
    logic                r_err;
    logic                w_req;
    logic                w_timeout;
    logic                w_fail;
    logic                w_end;
    logic                w_busy;
    logic                w_cyc;

    assign w_req     = bus.Ren | bus.Wen;
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_fail    = bus.ERR_I | w_timeout;
    assign w_end     = bus.ACK_I | w_fail;

    always_comb begin
        w_next = IDLE;
        w_busy = 1'b0;
        w_cyc  = 1'b0;
        w_next = (r_state == IDLE) ? (w_req ? BUS : IDLE) :
                 (r_state == BUS)  ? (w_end ? DONE : BUS) : IDLE;
        // the accept cycle already reports busy so the requester never sees a false completion
        w_busy = (r_state == IDLE) ? w_req : (r_state == BUS);
        w_cyc  = (r_state == BUS);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_we    <= 1'b0;
            r_load  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= 1'b0;
            if (r_state == IDLE && w_req) begin
                r_adr <= bus.ramaddr;
                r_dat <= bus.ramstore;
                r_we  <= bus.Wen & ~bus.Ren;
                r_cnt <= '0;
            end
            if (r_state == BUS) begin
                if (w_fail) begin
                    r_load <= ERR_DATA;
                    r_err  <= 1'b1;
                end else if (bus.ACK_I) begin
                    r_load <= r_we ? r_load : bus.DAT_I;
                end else if (r_cnt != CNT_W'(TIMEOUT)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.ramload = r_load;
    assign bus.busy_o  = w_busy;
    assign bus.err_o   = r_err;
    assign bus.ADR_O   = r_adr;
    assign bus.DAT_O   = r_dat;
    assign bus.SEL_O   = '1;
    assign bus.WE_O    = r_we;
    assign bus.CYC_O   = w_cyc;
    assign bus.STB_O   = w_cyc;
endmodule
